// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the 8-bit core: FETCH/DECODE/EXEC/MEM with req/ack
// memory handshakes, single-cycle datapath strobes, timeout fault and retire counter.
module multicycle_controller #(
    parameter int RETIRE_W    = 16,
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [3:0]          opcode_i,
    input  logic                flag_i,
    input  logic                imem_ack_i,
    input  logic                dmem_ack_i,
    output logic                imem_req_o,
    output logic                dmem_req_o,
    output logic                ir_w_en_o,
    output logic                pc_w_en_o,
    output logic                reg_w_en_o,
    output logic                mem_w_en_o,
    output logic                reg_mem_w_sel_o,
    output logic                alu_w_sel_o,
    output logic                flag_w_en_o,
    output logic                imm_en_o,
    output logic                ih_il_sel_o,
    output logic                jmp_en_o,
    output logic                je_en_o,
    output logic                illegal_o,
    output logic                fault_o,
    output logic [RETIRE_W-1:0] retired_o,
    output logic [2:0]          state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam bit                   TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [2:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RETIRE_W-1:0]  retired_q, retired_d;
    logic                 fault_q, fault_d;
    logic                 timeout_hit;

    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        retired_d       = retired_q;
        fault_d         = fault_q;
        imem_req_o      = 1'b0;
        dmem_req_o      = 1'b0;
        ir_w_en_o       = 1'b0;
        pc_w_en_o       = 1'b0;
        reg_w_en_o      = 1'b0;
        mem_w_en_o      = 1'b0;
        reg_mem_w_sel_o = 1'b0;
        alu_w_sel_o     = 1'b0;
        flag_w_en_o     = 1'b0;
        imm_en_o        = 1'b0;
        ih_il_sel_o     = 1'b0;
        jmp_en_o        = 1'b0;
        je_en_o         = 1'b0;
        illegal_o       = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_w_en_o = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_DECODE;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                pc_w_en_o = 1'b1;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_FETCH;
                case (opcode_i)
                    4'b0000: reg_w_en_o = 1'b1;
                    4'b0001, 4'b0011, 4'b0100, 4'b0101,
                    4'b0110, 4'b0111, 4'b1000: begin
                        reg_w_en_o  = 1'b1;
                        alu_w_sel_o = 1'b1;
                    end
                    4'b1001: begin
                        alu_w_sel_o = 1'b1;
                        flag_w_en_o = 1'b1;
                    end
                    4'b1010: je_en_o  = flag_i;
                    4'b1011: jmp_en_o = 1'b1;
                    4'b1100: begin
                        reg_w_en_o  = 1'b1;
                        imm_en_o    = 1'b1;
                        ih_il_sel_o = 1'b1;
                    end
                    4'b1101: begin
                        reg_w_en_o = 1'b1;
                        imm_en_o   = 1'b1;
                    end
                    4'b1110, 4'b1111: begin
                        pc_w_en_o = 1'b0;
                        retired_d = retired_q;
                        state_d   = S_MEM;
                    end
                    default: begin
                        // 0010 is undefined: skip it without counting it
                        illegal_o = 1'b1;
                        retired_d = retired_q;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                mem_w_en_o = (opcode_i == 4'b1111);
                if (dmem_ack_i) begin
                    reg_w_en_o      = (opcode_i == 4'b1110);
                    reg_mem_w_sel_o = (opcode_i == 4'b1110);
                    pc_w_en_o       = 1'b1;
                    retired_d       = retired_q + RETIRE_W'(1);
                    cnt_d           = '0;
                    state_d         = S_FETCH;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        // Reset masks outputs immediately, not only after the next edge
        if (!reset_i) begin
            imem_req_o      = 1'b0;
            dmem_req_o      = 1'b0;
            ir_w_en_o       = 1'b0;
            pc_w_en_o       = 1'b0;
            reg_w_en_o      = 1'b0;
            mem_w_en_o      = 1'b0;
            reg_mem_w_sel_o = 1'b0;
            alu_w_sel_o     = 1'b0;
            flag_w_en_o     = 1'b0;
            imm_en_o        = 1'b0;
            ih_il_sel_o     = 1'b0;
            jmp_en_o        = 1'b0;
            je_en_o         = 1'b0;
            illegal_o       = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    assign fault_o   = fault_q;
    assign retired_o = retired_q;
    assign state_o   = state_q;

endmodule
